// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_pkg
// Brief   : Shared channel-state encoding, button indices and helpers for the
//           button conditioner.
// Revision: 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE      = 2'd0;
    localparam btn_state_t ARMING    = 2'd1;
    localparam btn_state_t HELD      = 2'd2;
    localparam btn_state_t DISARMING = 2'd3;

    localparam int BTN_PAUSE    = 0;
    localparam int BTN_NEW_GAME = 1;
    localparam int BTN_DOWN     = 2;
    localparam int BTN_UP       = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module  : button_channel
// Brief   : One button: 2-flop synchroniser, debounce FSM, press/release
//           pulses and optional auto-repeat.
// Revision: 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    localparam logic [DW-1:0] C_DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] C_DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] C_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          r_sync1;
    logic          r_sync2;
    btn_state_t    r_state;
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    logic          r_rep_started;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    logic [RW-1:0] w_rep_last;

    // The first repeat waits the long delay, later ones the short period
    assign w_rep_last = r_rep_started ? C_PERIOD_LAST : C_DELAY_LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_state       <= IDLE;
            r_dcnt        <= '0;
            r_rcnt        <= '0;
            r_rep_started <= 1'b0;
            r_level       <= 1'b0;
            r_press       <= 1'b0;
            r_release     <= 1'b0;
            r_repeat      <= 1'b0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        r_state <= ARMING;
                        r_dcnt  <= DW'(1);
                    end
                end
                ARMING: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                    end else if (r_dcnt == C_DCNT_LAST) begin
                        r_state       <= HELD;
                        r_level       <= 1'b1;
                        r_press       <= 1'b1;
                        r_repeat      <= repeat_en;
                        r_rcnt        <= '0;
                        r_rep_started <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!r_sync2) begin
                        r_state <= DISARMING;
                        r_dcnt  <= DW'(1);
                    end
                    // rcnt reloads on each pulse, so it never wraps
                    if (r_rcnt == w_rep_last) begin
                        r_rcnt        <= '0;
                        r_rep_started <= 1'b1;
                        r_repeat      <= repeat_en;
                    end else begin
                        r_rcnt <= r_rcnt + RW'(1);
                    end
                end
                DISARMING: begin
                    if (r_sync2) begin
                        r_state <= HELD;
                    end else if (r_dcnt == C_DCNT_LAST) begin
                        r_state       <= IDLE;
                        r_level       <= 1'b0;
                        r_release     <= 1'b1;
                        r_rcnt        <= '0;
                        r_rep_started <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : button_conditioner
// Brief   : Synchronises and debounces the solo_squash button pins and
//           produces press/release/auto-repeat pulses per button.
// Revision: 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = 4,
    parameter int                     DEBOUNCE_CYCLES = 125000,
    parameter int                     REPEAT_DELAY    = 6250000,
    parameter int                     REPEAT_PERIOD   = 1250000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = NUM_BUTTONS'(4'b1100)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .repeat_en   (REPEAT_MASK[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_conditioner
// Brief   : Directed self-checking bench for button_conditioner.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5),
        .REPEAT_MASK     (4'b1100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_level",   32'(btn_level),   32'h0);
        check("reset_press",   32'(btn_press),   32'h0);
        check("reset_release", 32'(btn_release), 32'h0);
        check("reset_repeat",  32'(btn_repeat),  32'h0);

        // 1. clean press on new_game (repeat masked)
        btn_raw[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("t1_level_e%0d", e), 32'(btn_level[1]), 32'(e >= 6));
            check($sformatf("t1_press_e%0d", e), 32'(btn_press[1]), 32'(e == 6));
            check($sformatf("t1_repeat_e%0d", e), 32'(btn_repeat[1]), 32'h0);
        end

        // 2. bounce on pause
        for (int e = 1; e <= 20; e++) begin
            btn_raw[0] = (e % 2 == 1);
            tick();
            check($sformatf("t2_level_e%0d", e), 32'(btn_level[0]), 32'h0);
            check($sformatf("t2_press_e%0d", e), 32'(btn_press[0]), 32'h0);
            check($sformatf("t2_release_e%0d", e), 32'(btn_release[0]), 32'h0);
        end
        btn_raw[0] = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check($sformatf("t2_tail_level_e%0d", e), 32'(btn_level[0]), 32'h0);
            check($sformatf("t2_tail_release_e%0d", e), 32'(btn_release[0]), 32'h0);
        end

        // 3. up_key held, then release with a one-cycle glitch
        btn_raw[3] = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        check("t3_held_level", 32'(btn_level[3]), 32'h1);
        btn_raw[3] = 1'b0;
        tick();
        check("t3_g1_release", 32'(btn_release[3]), 32'h0);
        tick();
        check("t3_g2_release", 32'(btn_release[3]), 32'h0);
        btn_raw[3] = 1'b1;
        tick();
        check("t3_g3_release", 32'(btn_release[3]), 32'h0);
        btn_raw[3] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("t3_release_e%0d", e), 32'(btn_release[3]), 32'(e == 6));
            check($sformatf("t3_level_e%0d", e), 32'(btn_level[3]), 32'(e < 6));
        end

        // 4. auto-repeat on down_key: pulses at edges 6, 16, 21, 26, ...
        btn_raw[2] = 1'b1;
        for (int e = 1; e <= 46; e++) begin
            tick();
            check($sformatf("t4_repeat_e%0d", e), 32'(btn_repeat[2]),
                  32'((e == 6) || (e >= 16 && (e - 16) % 5 == 0)));
            check($sformatf("t4_press_e%0d", e), 32'(btn_press[2]), 32'(e == 6));
        end
        btn_raw[2] = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        check("t4_released_level", 32'(btn_level[2]), 32'h0);

        // 5. reset while up_key held
        btn_raw[3] = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        check("t5_held_level", 32'(btn_level[3]), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_level",   32'(btn_level),   32'h0);
        check("t5_rst_press",   32'(btn_press),   32'h0);
        check("t5_rst_release", 32'(btn_release), 32'h0);
        check("t5_rst_repeat",  32'(btn_repeat),  32'h0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("t5_press_e%0d", e), 32'(btn_press[3]), 32'(e == 6));
            check($sformatf("t5_level_e%0d", e), 32'(btn_level[3]), 32'(e >= 6));
            check($sformatf("t5_release_e%0d", e), 32'(btn_release), 32'h0);
        end

        // 6. all four buttons pressed together from a clean idle
        btn_raw = '0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        btn_raw = 4'b1111;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("t6_press_e%0d", e), 32'(btn_press), (e == 6) ? 32'hF : 32'h0);
            check($sformatf("t6_repeat_e%0d", e), 32'(btn_repeat), (e == 6) ? 32'hC : 32'h0);
            check($sformatf("t6_level_e%0d", e), 32'(btn_level), (e >= 6) ? 32'hF : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
